// File: rtl/servant_wb_mux_pkg.sv
// Shared definitions for servant_wb_mux: FSM state encodings, default
// slave decode windows and the timeout counter width helper.
package servant_wb_mux_pkg;

  // FSM state encodings
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  // Default slave map: slot i lives in bits [32*i +: 32]
  localparam int              DEF_NUM_SLAVES     = 4;
  localparam logic [4*32-1:0] DEF_SLAVE_BASE     = {32'h4000_0000, 32'h8000_0000,
                                                    32'hC000_0000, 32'h0000_0000};
  localparam logic [4*32-1:0] DEF_SLAVE_MASK     = {4{32'hC000_0000}};
  localparam int              DEF_TIMEOUT_CYCLES = 255;

  // Timeout counter width: enough to hold TIMEOUT_CYCLES, clamped to 8..32 bits
  function automatic int tmo_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8)  w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

endpackage

// File: rtl/servant_wb_mux_if.sv
// Wishbone-classic bundle between the CPU-side master, the mux and the
// NUM_SLAVES peripherals. The slave modport is the mux view (it is the
// slave of the CPU and drives the broadcast peripheral bus); the master
// modport is the view of the surrounding system.
interface servant_wb_mux_if #(
  parameter int NUM_SLAVES = 4
);
  // CPU side
  logic [31:0]            wb_cpu_adr;
  logic [31:0]            wb_cpu_dat;
  logic [3:0]             wb_cpu_sel;
  logic                   wb_cpu_we;
  logic                   wb_cpu_cyc;
  logic [31:0]            wb_cpu_rdt;
  logic                   wb_cpu_ack;
  // Peripheral side
  logic [31:0]            wb_s_adr;
  logic [31:0]            wb_s_dat;
  logic [3:0]             wb_s_sel;
  logic                   wb_s_we;
  logic [NUM_SLAVES-1:0]  wb_s_cyc;
  logic [NUM_SLAVES*32-1:0] wb_s_rdt;
  logic [NUM_SLAVES-1:0]  wb_s_ack;

  modport slave (
    input  wb_cpu_adr, wb_cpu_dat, wb_cpu_sel, wb_cpu_we, wb_cpu_cyc,
    output wb_cpu_rdt, wb_cpu_ack,
    output wb_s_adr, wb_s_dat, wb_s_sel, wb_s_we, wb_s_cyc,
    input  wb_s_rdt, wb_s_ack
  );

  modport master (
    output wb_cpu_adr, wb_cpu_dat, wb_cpu_sel, wb_cpu_we, wb_cpu_cyc,
    input  wb_cpu_rdt, wb_cpu_ack,
    input  wb_s_adr, wb_s_dat, wb_s_sel, wb_s_we, wb_s_cyc,
    output wb_s_rdt, wb_s_ack
  );

endinterface

// File: rtl/servant_addr_dec.sv
// Combinational address decoder: compares the address against each
// BASE/MASK window and returns a one-hot vector of the lowest-index hit.
module servant_addr_dec #(
  parameter int                      NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0
) (
  input  logic [31:0]           i_adr,
  output logic [NUM_SLAVES-1:0] o_hit_vec,
  output logic                  o_hit
);

  // Priority decode: scan from the top so the lowest matching index wins
  always_comb begin
    // NOTE: outputs get a default before the loop; a path that left them
    // unassigned would infer a latch.
    o_hit_vec = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_adr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])
        o_hit_vec = NUM_SLAVES'(1) << i;
    end
    o_hit = |o_hit_vec;
  end

endmodule

// File: rtl/servant_wb_mux.sv
// Wishbone-classic decoder/mux from the arbitrated SERV bus to NUM_SLAVES
// peripherals. Each request is decoded once in IDLE, forwarded to exactly
// one slave in ACTIVE, and answered with a single registered ack.
// Optional bus timeout: define SERVANT_MUX_TIMEOUT_EN.
module servant_wb_mux
  import servant_wb_mux_pkg::*;
#(
  parameter int                       NUM_SLAVES = DEF_NUM_SLAVES,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = DEF_SLAVE_MASK
`ifdef SERVANT_MUX_TIMEOUT_EN
  ,
  parameter int                       TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  servant_wb_mux_if.slave       wb,
  output logic                  o_timeout
);

  logic [1:0]            r_state;
  logic [NUM_SLAVES-1:0] r_s_cyc;   // latched one-hot slave select
  logic                  r_ack;
  logic [31:0]           r_rdt;
  logic                  r_timeout;

  logic [NUM_SLAVES-1:0] w_hit_vec;
  logic                  w_hit;
  logic                  w_s_ack;
  logic [31:0]           w_s_rdt;
  logic                  w_expire;

  servant_addr_dec #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_addr_dec (
    .i_adr     (wb.wb_cpu_adr),
    .o_hit_vec (w_hit_vec),
    .o_hit     (w_hit)
  );

  // Broadcast signals are plain pass-through; only cyc is steered
  assign wb.wb_s_adr   = wb.wb_cpu_adr;
  assign wb.wb_s_dat   = wb.wb_cpu_dat;
  assign wb.wb_s_sel   = wb.wb_cpu_sel;
  assign wb.wb_s_we    = wb.wb_cpu_we;
  assign wb.wb_s_cyc   = r_s_cyc;
  assign wb.wb_cpu_ack = r_ack;
  assign wb.wb_cpu_rdt = r_rdt;
  assign o_timeout     = r_timeout;

  // Only the selected slave's ack and read data are visible to the FSM
  always_comb begin
    w_s_ack = |(wb.wb_s_ack & r_s_cyc);
    w_s_rdt = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_s_cyc[i])
        w_s_rdt = w_s_rdt | wb.wb_s_rdt[32*i +: 32];
    end
  end

`ifdef SERVANT_MUX_TIMEOUT_EN
  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  // Expire on the TIMEOUT_CYCLES-th ACTIVE cycle without a slave ack
  assign w_expire = (r_state == S_ACTIVE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count ACTIVE cycles; held at zero elsewhere so every entry starts fresh
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_cnt <= '0;
    else if (r_state != S_ACTIVE)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end
`else
  // Without the timeout feature ACTIVE waits for the slave indefinitely
  assign w_expire = 1'b0;
`endif

  // Transaction FSM: decode, forward, acknowledge
  always_ff @(posedge i_clk) begin
    // NOTE: every register here, read data included, has a defined reset
    // value because software can observe o_wb_cpu_rdt right after reset.
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_s_cyc   <= '0;
      r_ack     <= 1'b0;
      r_rdt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the defaults below
      // are simply overridden by later assignments in the same cycle.
      r_ack     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wb.wb_cpu_cyc) begin
            if (w_hit) begin
              r_s_cyc <= w_hit_vec;
              r_state <= S_ACTIVE;
            end else begin
              // Unmapped: reads return zero, writes are dropped
              r_rdt   <= '0;
              r_ack   <= 1'b1;
              r_state <= S_ACK;
            end
          end
        end
        S_ACTIVE: begin
          if (!wb.wb_cpu_cyc) begin
            // Abort beats a coincident slave ack
            r_s_cyc <= '0;
            r_state <= S_IDLE;
          end else if (w_s_ack) begin
            r_s_cyc <= '0;
            r_rdt   <= wb.wb_cpu_we ? 32'h0 : w_s_rdt;
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end else if (w_expire) begin
            r_s_cyc   <= '0;
            r_rdt     <= '0;
            r_ack     <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= S_ACK;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_s_cyc <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servant_wb_mux.sv
// Directed testbench for servant_wb_mux with a scoreboard of expected
// CPU acks. Slave map used here:
//   slot0 base 0000_0000 mask C000_0000
//   slot1 base 8000_0000 mask C000_0000
//   slot2 base 0000_0000 mask F000_0000 (overlaps slot0)
//   slot3 base 4000_0000 mask C000_0000
//   C000_0000.. is unmapped
module tb_servant_wb_mux;

  localparam int NS = 4;
  localparam logic [NS*32-1:0] TB_BASE = {32'h4000_0000, 32'h0000_0000,
                                          32'h8000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] TB_MASK = {32'hC000_0000, 32'hF000_0000,
                                          32'hC000_0000, 32'hC000_0000};

  typedef struct packed {
    logic [31:0] rdt;
    logic [7:0]  lat;
    logic        tmo;
  } exp_t;

  logic clk;
  logic rst;
  logic timeout;

  int n_cmp;
  int n_mis;
  int t;
  int t_req;
  exp_t sb_q[$];

  servant_wb_mux_if #(.NUM_SLAVES(NS)) bus ();

  servant_wb_mux #(
    .NUM_SLAVES (NS),
    .SLAVE_BASE (TB_BASE),
    .SLAVE_MASK (TB_MASK)
`ifdef SERVANT_MUX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (8)
`endif
  ) u_dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .wb        (bus),
    .o_timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge
  task automatic tick();
    @(negedge clk);
    t++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
    bus.wb_cpu_adr = adr;
    bus.wb_cpu_dat = dat;
    bus.wb_cpu_sel = sel;
    bus.wb_cpu_we  = we;
    bus.wb_cpu_cyc = 1'b1;
    t_req = t;
  endtask

  task automatic expect_ack(input logic [31:0] rdt, input int lat, input logic tmo);
    sb_q.push_back('{rdt: rdt, lat: 8'(lat), tmo: tmo});
  endtask

  // Wait (bounded) for a CPU ack, then compare it with the scoreboard head
  task automatic await_ack(input int max_wait);
    int   n;
    exp_t e;
    n = 0;
    while (bus.wb_cpu_ack !== 1'b1 && n < max_wait) begin
      tick();
      n++;
    end
    check("cpu_ack_seen", 32'(bus.wb_cpu_ack), 32'd1);
    if (bus.wb_cpu_ack === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("ack_rdt", bus.wb_cpu_rdt, e.rdt);
      check("ack_latency", 32'(t - t_req), 32'(e.lat));
      check("ack_timeout_flag", 32'(timeout), 32'(e.tmo));
    end
  endtask

  task automatic idle_bus();
    bus.wb_cpu_cyc = 1'b0;
    bus.wb_cpu_we  = 1'b0;
    bus.wb_s_ack   = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    t     = 0;
    t_req = 0;
    rst   = 1'b1;
    bus.wb_cpu_adr = '0;
    bus.wb_cpu_dat = '0;
    bus.wb_cpu_sel = '0;
    bus.wb_cpu_we  = 1'b0;
    bus.wb_cpu_cyc = 1'b0;
    bus.wb_s_ack   = '0;
    bus.wb_s_rdt   = {32'h3333_3333, 32'h0C0C_0002, 32'hCAFE_F00D, 32'h0A0A_0000};

    // Reset state
    tick(); tick(); tick();
    check("rst_ack", 32'(bus.wb_cpu_ack), 32'd0);
    check("rst_rdt", bus.wb_cpu_rdt, 32'd0);
    check("rst_s_cyc", 32'(bus.wb_s_cyc), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    tick();

    // Read slave 1, slave answers in its first s_cyc cycle
    issue(32'h8000_0010, 32'h0, 4'hF, 1'b0);
    expect_ack(32'hCAFE_F00D, 2, 1'b0);
    tick();
    check("rd1_s_cyc", 32'(bus.wb_s_cyc), 32'h2);
    check("rd1_s_adr", bus.wb_s_adr, 32'h8000_0010);
    check("rd1_no_early_ack", 32'(bus.wb_cpu_ack), 32'd0);
    bus.wb_s_ack = 4'b0010;
    await_ack(4);
    idle_bus();
    tick();
    check("rd1_ack_pulse", 32'(bus.wb_cpu_ack), 32'd0);
    check("rd1_s_cyc_off", 32'(bus.wb_s_cyc), 32'd0);

    // Write slave 0, slave acks late; read data of a write is zero
    issue(32'h1000_0100, 32'h1234_5678, 4'b0011, 1'b1);
    expect_ack(32'h0, 4, 1'b0);
    tick();
    check("wr0_s_cyc", 32'(bus.wb_s_cyc), 32'h1);
    check("wr0_s_dat", bus.wb_s_dat, 32'h1234_5678);
    check("wr0_s_sel", 32'(bus.wb_s_sel), 32'h3);
    check("wr0_s_we", 32'(bus.wb_s_we), 32'd1);
    tick();
    check("wr0_wait_no_ack", 32'(bus.wb_cpu_ack), 32'd0);
    tick();
    bus.wb_s_ack = 4'b0001;
    await_ack(4);
    idle_bus();
    tick();
    check("wr0_ack_pulse", 32'(bus.wb_cpu_ack), 32'd0);

    // Overlapping windows: slot 0 wins, stray ack from slot 2 ignored
    issue(32'h0000_0040, 32'h0, 4'hF, 1'b0);
    expect_ack(32'h0A0A_0000, 3, 1'b0);
    tick();
    check("ovl_s_cyc", 32'(bus.wb_s_cyc), 32'h1);
    bus.wb_s_ack = 4'b0100;
    tick();
    check("ovl_stray_ignored", 32'(bus.wb_cpu_ack), 32'd0);
    check("ovl_s_cyc_held", 32'(bus.wb_s_cyc), 32'h1);
    bus.wb_s_ack = 4'b0001;
    await_ack(4);
    idle_bus();
    tick();

    // Reset in ACTIVE with a slave ack in flight
    issue(32'h8000_0020, 32'h0, 4'hF, 1'b0);
    tick();
    check("rstx_s_cyc", 32'(bus.wb_s_cyc), 32'h2);
    rst = 1'b1;
    bus.wb_s_ack = 4'b0010;
    tick();
    check("rstx_s_cyc_off", 32'(bus.wb_s_cyc), 32'd0);
    check("rstx_ack", 32'(bus.wb_cpu_ack), 32'd0);
    check("rstx_rdt", bus.wb_cpu_rdt, 32'd0);
    check("rstx_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    idle_bus();
    tick();
    check("rstx_ack_discarded", 32'(bus.wb_cpu_ack), 32'd0);

    // Read slave 3 so read data is non-zero before the unmapped access
    issue(32'h4000_0000, 32'h0, 4'hF, 1'b0);
    expect_ack(32'h3333_3333, 2, 1'b0);
    tick();
    check("rd3_s_cyc", 32'(bus.wb_s_cyc), 32'h8);
    bus.wb_s_ack = 4'b1000;
    await_ack(4);
    idle_bus();
    tick();

    // Unmapped read: ack after one cycle, zero data, no slave selected
    issue(32'hC000_1234, 32'h0, 4'hF, 1'b0);
    expect_ack(32'h0, 1, 1'b0);
    tick();
    check("unm_s_cyc", 32'(bus.wb_s_cyc), 32'd0);
    await_ack(2);
    // cyc held through the ack: the following IDLE starts a new request
    tick();
    check("b2b_gap", 32'(bus.wb_cpu_ack), 32'd0);
    issue(32'hC000_1234, 32'h0, 4'hF, 1'b0);
    expect_ack(32'h0, 1, 1'b0);
    await_ack(3);
    idle_bus();
    tick();
    check("b2b_ack_pulse", 32'(bus.wb_cpu_ack), 32'd0);

    // Abort coincident with slave ack: abort wins, no cpu ack
    issue(32'h4000_0004, 32'h0, 4'hF, 1'b0);
    tick();
    check("abt_s_cyc", 32'(bus.wb_s_cyc), 32'h8);
    bus.wb_cpu_cyc = 1'b0;
    bus.wb_s_ack   = 4'b1000;
    tick();
    check("abt_s_cyc_off", 32'(bus.wb_s_cyc), 32'd0);
    check("abt_no_ack", 32'(bus.wb_cpu_ack), 32'd0);
    idle_bus();
    tick();
    check("abt_no_late_ack", 32'(bus.wb_cpu_ack), 32'd0);

`ifdef SERVANT_MUX_TIMEOUT_EN
    // Slave never answers: timeout ack after 8 ACTIVE cycles
    issue(32'h4000_0008, 32'h0, 4'hF, 1'b0);
    expect_ack(32'h0, 9, 1'b1);
    tick();
    check("tmo_s_cyc", 32'(bus.wb_s_cyc), 32'h8);
    await_ack(12);
    check("tmo_s_cyc_off", 32'(bus.wb_s_cyc), 32'd0);
    idle_bus();
    tick();
    check("tmo_pulse_end", 32'(timeout), 32'd0);
`else
    // Slave never answers: the mux keeps waiting, no timeout pulse
    issue(32'h4000_0008, 32'h0, 4'hF, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("wait_no_ack", 32'(bus.wb_cpu_ack), 32'd0);
    check("wait_s_cyc", 32'(bus.wb_s_cyc), 32'h8);
    check("wait_no_timeout", 32'(timeout), 32'd0);
    idle_bus();
    tick();
    check("wait_abort_s_cyc", 32'(bus.wb_s_cyc), 32'd0);
`endif

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
